// File: rtl/lsu_byte_sequencer_if.sv
// Request/response handshake plus Mem data-port bundle for lsu_byte_sequencer.
// master = CPU datapath and Mem side, slave = the sequencer.
interface lsu_byte_sequencer_if #(
  parameter int AW = 32
);
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [2:0]    req_funct3;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          resp_valid;
  logic [31:0]   resp_rdata;
  logic          resp_err;
  logic [AW-1:0] mem_addr;
  logic [1:0]    mem_size;
  logic [31:0]   mem_wdata;
  logic          mem_we;
  logic [31:0]   mem_rdata;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  mem_addr, mem_size, mem_wdata, mem_we
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output mem_addr, mem_size, mem_wdata, mem_we
  );
endinterface

// File: rtl/lsu_byte_sequencer.sv
// Single-outstanding RISC-V load/store sequencer on Mem's data port; falling-edge state.
// LSU_MISALIGN_EN splits misaligned H/HU/W into byte beats, otherwise those requests error.
module lsu_byte_sequencer #(
  parameter int AW = 32
) (
  input logic                 clk,
  input logic                 RST,
  lsu_byte_sequencer_if.slave bus
);

  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

  state_t        state_q, state_d;
  logic          we_q, err_q;
  logic [2:0]    f3_q;
  logic [AW-1:0] addr_q;
  logic [31:0]   wdata_q, asm_q;
  logic          legal, misaligned, reject, accept, last_beat;
  logic          split_w;
  logic [1:0]    beat_w;

`ifdef LSU_MISALIGN_EN
  localparam bit SPLIT_EN = 1'b1;
  logic       split_q;
  logic [1:0] beat_q;
  assign split_w   = split_q;
  assign beat_w    = beat_q;
  assign last_beat = !split_q || (beat_q == (f3_q[1] ? 2'd3 : 2'd1));
`else
  localparam bit SPLIT_EN = 1'b0;
  assign split_w   = 1'b0;
  assign beat_w    = 2'd0;
  assign last_beat = 1'b1;
`endif

  always_comb begin
    legal      = bus.req_we ? (bus.req_funct3 inside {3'b000, 3'b001, 3'b010})
                            : (bus.req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
    misaligned = ((bus.req_funct3[1:0] == 2'b01) && bus.req_addr[0]) ||
                 ((bus.req_funct3[1:0] == 2'b10) && (bus.req_addr[1:0] != 2'b00));
    reject     = !legal || (misaligned && !SPLIT_EN);
  end

  assign accept = bus.req_valid && (state_q == IDLE);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.req_valid) state_d = reject ? DONE : ACCESS;
      ACCESS:  if (last_beat) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(negedge clk or negedge RST) begin
    if (!RST) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      f3_q    <= 3'b000;
      addr_q  <= '0;
      wdata_q <= '0;
      asm_q   <= '0;
`ifdef LSU_MISALIGN_EN
      split_q <= 1'b0;
      beat_q  <= 2'd0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= bus.req_we;
        err_q   <= reject;
        f3_q    <= bus.req_funct3;
        addr_q  <= bus.req_addr;
        wdata_q <= bus.req_wdata;
        asm_q   <= '0;
`ifdef LSU_MISALIGN_EN
        split_q <= misaligned;
        beat_q  <= 2'd0;
`endif
      end else if (state_q == ACCESS) begin
`ifdef LSU_MISALIGN_EN
        // Split loads land one byte per beat in little-endian order.
        if (split_q) begin
          beat_q <= beat_q + 2'd1;
          if (!we_q) asm_q[{beat_q, 3'b000} +: 8] <= bus.mem_rdata[7:0];
        end else if (!we_q) begin
          asm_q <= bus.mem_rdata;
        end
`else
        if (!we_q) asm_q <= bus.mem_rdata;
`endif
      end
    end
  end

  // Memory-port outputs come only from latched request state.
  always_comb begin
    bus.req_ready = (state_q == IDLE);
    bus.mem_addr  = '0;
    bus.mem_size  = 2'b00;
    bus.mem_wdata = '0;
    bus.mem_we    = 1'b0;
    if (state_q == ACCESS) begin
      bus.mem_we = we_q;
      if (split_w) begin
        bus.mem_addr = addr_q + AW'(beat_w);
        if (we_q) bus.mem_wdata = {4{wdata_q[{beat_w, 3'b000} +: 8]}};
      end else begin
        bus.mem_addr = addr_q;
        bus.mem_size = f3_q[1:0];
        if (we_q) bus.mem_wdata = wdata_q;
      end
    end
  end

  always_comb begin
    bus.resp_valid = (state_q == DONE);
    bus.resp_err   = (state_q == DONE) && err_q;
    bus.resp_rdata = '0;
    if ((state_q == DONE) && !err_q && !we_q) begin
      case (f3_q)
        3'b000:  bus.resp_rdata = {{24{asm_q[7]}}, asm_q[7:0]};
        3'b100:  bus.resp_rdata = {24'd0, asm_q[7:0]};
        3'b001:  bus.resp_rdata = {{16{asm_q[15]}}, asm_q[15:0]};
        3'b101:  bus.resp_rdata = {16'd0, asm_q[15:0]};
        default: bus.resp_rdata = asm_q;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_byte_sequencer.sv
// Randomized scoreboard bench for lsu_byte_sequencer; behaviour follows LSU_MISALIGN_EN.
module tb_lsu_byte_sequencer;

`ifdef LSU_MISALIGN_EN
  localparam bit SPLIT = 1'b1;
`else
  localparam bit SPLIT = 1'b0;
`endif

  logic clk = 1'b1;
  logic RST = 1'b0;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;
  always @(negedge clk) cyc <= cyc + 1;

  lsu_byte_sequencer_if #(.AW(32)) bus ();

  lsu_byte_sequencer #(.AW(32)) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  typedef struct packed {
    logic [31:0]       acc;
    logic [2:0]        nb;
    logic [3:0][31:0]  b_addr;
    logic [3:0][1:0]   b_size;
    logic [3:0][31:0]  b_wdata;
    logic              we;
    logic [31:0]       rdata;
    logic              err;
  } exp_t;

  exp_t sb[$];
  logic [7:0] tb_mem  [logic [31:0]];
  logic [7:0] ref_mem [logic [31:0]];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ 8'hA5;
  endfunction

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    return tb_mem.exists(a) ? tb_mem[a] : dflt(a);
  endfunction

  function automatic logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    tb_mem[a]  = b;
    ref_mem[a] = b;
  endtask

  // Reference: architectural outcome and beat list of one request.
  function automatic exp_t model(input logic we, input logic [2:0] f3,
                                 input logic [31:0] addr, input logic [31:0] wd);
    exp_t        e;
    int          n;
    logic [31:0] v;
    e    = '0;
    e.we = we;
    n    = 1 << f3[1:0];
    if (we ? (f3 > 3'd2) : (f3 == 3'd3 || f3 > 3'd5)) begin
      e.err = 1'b1;
    end else if (((addr & 32'(n - 1)) != 0) && !SPLIT) begin
      e.err = 1'b1;
    end else begin
      if ((addr & 32'(n - 1)) == 0) begin
        e.nb        = 3'd1;
        e.b_addr[0] = addr;
        e.b_size[0] = f3[1:0];
        e.b_wdata[0] = wd;
      end else begin
        e.nb = 3'(n);
        for (int k = 0; k < n; k++) begin
          e.b_addr[k]  = addr + 32'(k);
          e.b_size[k]  = 2'b00;
          e.b_wdata[k] = {4{wd[8*k +: 8]}};
        end
      end
      if (!we) begin
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_rd(addr + 32'(i))) << (8 * i));
        if (n < 4 && !f3[2] && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
        e.rdata = v;
      end
    end
    return e;
  endfunction

  function automatic void commit_beat(input exp_t e, input int k);
    logic [31:0] a;
    if (e.we && !e.err) begin
      for (int i = 0; i < (1 << e.b_size[k]); i++) begin
        a = e.b_addr[k] + 32'(i);
        ref_mem[a] = e.b_wdata[k][8*i +: 8];
      end
    end
  endfunction

  // Memory model: combinational read data settled mid-cycle, writes commit at the falling edge.
  logic        cap_we = 1'b0;
  logic [31:0] cap_addr = '0, cap_wdata = '0;
  logic [1:0]  cap_size = '0;

  always @(posedge clk) begin
    cap_we    = bus.mem_we;
    cap_addr  = bus.mem_addr;
    cap_size  = bus.mem_size;
    cap_wdata = bus.mem_wdata;
    case (bus.mem_size)
      2'b00:   bus.mem_rdata = {4{mem_rd(bus.mem_addr)}};
      2'b01:   bus.mem_rdata = {2{mem_rd(bus.mem_addr + 32'd1), mem_rd(bus.mem_addr)}};
      default: bus.mem_rdata = {mem_rd(bus.mem_addr + 32'd3), mem_rd(bus.mem_addr + 32'd2),
                                mem_rd(bus.mem_addr + 32'd1), mem_rd(bus.mem_addr)};
    endcase
  end

  always @(negedge clk) begin
    if (RST && cap_we)
      for (int i = 0; i < (1 << cap_size); i++) tb_mem[cap_addr + 32'(i)] = cap_wdata[8*i +: 8];
  end

  // Monitor: beat contents by cycle offset from accept, handshake, and responses.
  always @(posedge clk) begin : mon
    int rel;
    int k;
    if (RST) begin
      rel = (sb.size() != 0) ? (cyc - int'(sb[0].acc) + 1) : 0;
      chk("req_ready", 32'(bus.req_ready), 32'(sb.size() == 0));
      if (sb.size() != 0 && rel >= 1 && rel <= int'(sb[0].nb)) begin
        k = rel - 1;
        chk("beat_addr", bus.mem_addr, sb[0].b_addr[k]);
        chk("beat_size", 32'(bus.mem_size), 32'(sb[0].b_size[k]));
        chk("beat_we", 32'(bus.mem_we), 32'(sb[0].we));
        if (sb[0].we) chk("beat_wdata", bus.mem_wdata, sb[0].b_wdata[k]);
      end else begin
        chk("idle_mem_we", 32'(bus.mem_we), 32'd0);
        chk("idle_mem_addr", bus.mem_addr, 32'd0);
        chk("idle_mem_size", 32'(bus.mem_size), 32'd0);
        chk("idle_mem_wdata", bus.mem_wdata, 32'd0);
      end
      if (bus.resp_valid) begin
        if (sb.size() == 0) begin
          chk("resp_unexpected", 32'(bus.resp_valid), 32'd0);
        end else begin
          chk("resp_latency", 32'(rel), 32'(sb[0].nb) + 32'd1);
          chk("resp_rdata", bus.resp_rdata, sb[0].rdata);
          chk("resp_err", 32'(bus.resp_err), 32'(sb[0].err));
          void'(sb.pop_front());
        end
      end else if (sb.size() != 0 && rel > int'(sb[0].nb) + 1) begin
        chk("resp_timeout", 32'(rel), 32'(sb[0].nb) + 32'd1);
        void'(sb.pop_front());
      end
    end
  end

  // Presents a request and holds it until accepted; req_valid stays high on return.
  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input bit commit, output exp_t e, output bit ok);
    int n;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    ok = 1'b0;
    n  = 0;
    e  = '0;
    while (!bus.req_ready && n < 30) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("accept_wait", 32'(bus.req_ready), 32'd1);
    if (!bus.req_ready) begin
      bus.req_valid = 1'b0;
      return;
    end
    e = model(we, f3, addr, wd);
    @(negedge clk);
    #1;
    e.acc = 32'(cyc);
    sb.push_back(e);
    if (commit) for (int k = 0; k < int'(e.nb); k++) commit_beat(e, k);
    ok = 1'b1;
  endtask

  task automatic idle();
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'($urandom);
    bus.req_funct3 = 3'($urandom);
    bus.req_addr   = $urandom;
    bus.req_wdata  = $urandom;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 30 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_pending", 32'(sb.size()), 32'd0);
  endtask

  task automatic check_reset();
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
    chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
    chk("rst_mem_addr", bus.mem_addr, 32'd0);
    chk("rst_mem_size", 32'(bus.mem_size), 32'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 32'd0);
    chk("rst_mem_we", 32'(bus.mem_we), 32'd0);
  endtask

  // Asserts reset during cycle r after accept; beats that ended before it stay committed.
  task automatic reset_mid(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wd, input int r);
    exp_t e;
    bit   ok;
    issue(we, f3, addr, wd, 1'b0, e, ok);
    idle();
    if (ok) begin
      repeat (r) @(posedge clk);
      #1;
      RST = 1'b0;
      sb.delete();
      for (int k = 0; k < int'(e.nb) && k < r - 1; k++) commit_beat(e, k);
      #1;
      check_reset();
      @(posedge clk);
      #2;
      RST = 1'b1;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    exp_t        ea, eb, ec;
    bit          ok;
    logic [31:0] bases [3];
    logic [31:0] a;
    logic        we;
    logic [2:0]  f3;
    bases = '{32'h0000_0100, 32'h0000_0200, 32'hFFFF_FFF4};
    idle();
    #2;
    check_reset();
    @(posedge clk);
    #2;
    RST = 1'b1;
    @(posedge clk);
    #1;

    preload(32'h100, 8'h78); preload(32'h101, 8'h56);
    preload(32'h102, 8'h34); preload(32'h103, 8'h12);
    issue(1'b0, 3'b010, 32'h100, 32'd0, 1'b1, ea, ok); idle(); wait_idle();

    preload(32'h101, 8'h80); preload(32'h102, 8'hFE); preload(32'h103, 8'hFF);
    issue(1'b0, 3'b000, 32'h101, 32'd0, 1'b1, ea, ok); idle(); wait_idle();
    issue(1'b0, 3'b100, 32'h101, 32'd0, 1'b1, ea, ok); idle(); wait_idle();
    issue(1'b0, 3'b101, 32'h102, 32'd0, 1'b1, ea, ok); idle(); wait_idle();

    issue(1'b1, 3'b010, 32'h203, 32'hAABB_CCDD, 1'b1, ea, ok); idle(); wait_idle();
    if (SPLIT) begin
      chk("sw203_b0", 32'(mem_rd(32'h203)), 32'hDD);
      chk("sw203_b3", 32'(mem_rd(32'h206)), 32'hAA);
    end else begin
      chk("sw203_b0_kept", 32'(mem_rd(32'h203)), 32'(dflt(32'h203)));
      chk("sw203_b3_kept", 32'(mem_rd(32'h206)), 32'(dflt(32'h206)));
    end
    issue(1'b0, 3'b010, 32'h203, 32'd0, 1'b1, ea, ok); idle(); wait_idle();
    issue(1'b0, 3'b001, 32'hFFFF_FFFF, 32'd0, 1'b1, ea, ok); idle(); wait_idle();

    issue(1'b0, 3'b011, 32'h104, 32'd0, 1'b1, ea, ok); idle(); wait_idle();
    issue(1'b1, 3'b100, 32'h108, 32'h5555_AAAA, 1'b1, ea, ok); idle(); wait_idle();

    // Held req_valid: each accept lands in the first idle cycle after the previous DONE.
    issue(1'b0, 3'b010, 32'h100, 32'd0, 1'b1, ea, ok);
    issue(1'b1, 3'b001, 32'h301, 32'h0000_BEEF, 1'b1, eb, ok);
    issue(1'b0, 3'b101, 32'h301, 32'd0, 1'b1, ec, ok);
    idle();
    chk("b2b_gap_ab", eb.acc - ea.acc, 32'(ea.nb) + 32'd2);
    chk("b2b_gap_bc", ec.acc - eb.acc, 32'(eb.nb) + 32'd2);
    wait_idle();

    for (int i = 0; i < 4; i++) begin
      preload(32'h203 + 32'(i), 8'h11);
      preload(32'h200 + 32'(i), 8'h11);
    end
    if (SPLIT) begin
      reset_mid(1'b1, 3'b010, 32'h203, 32'hAABB_CCDD, 3);
      chk("rst_sw_b0", 32'(mem_rd(32'h203)), 32'hDD);
      chk("rst_sw_b1", 32'(mem_rd(32'h204)), 32'hCC);
      chk("rst_sw_b2", 32'(mem_rd(32'h205)), 32'h11);
      chk("rst_sw_b3", 32'(mem_rd(32'h206)), 32'h11);
    end else begin
      reset_mid(1'b1, 3'b010, 32'h200, 32'hAABB_CCDD, 1);
      chk("rst_sw_b0", 32'(mem_rd(32'h200)), 32'h11);
      chk("rst_sw_b3", 32'(mem_rd(32'h203)), 32'h11);
    end

    for (int i = 0; i < 300; i++) begin
      we = 1'($urandom);
      f3 = 3'($urandom_range(0, 7));
      a  = bases[$urandom_range(0, 2)] + 32'($urandom_range(0, 15));
      issue(we, f3, a, $urandom, 1'b1, ea, ok);
      if ($urandom_range(0, 1) == 0) begin
        idle();
        repeat ($urandom_range(0, 3)) begin
          @(posedge clk);
          #1;
        end
      end
    end
    idle();
    wait_idle();

    foreach (ref_mem[k]) chk($sformatf("mem_%h", k), 32'(mem_rd(k)), 32'(ref_mem[k]));
    foreach (tb_mem[k])  chk($sformatf("mem_extra_%h", k), 32'(tb_mem[k]), 32'(ref_rd(k)));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_byte_sequencer.md
# lsu_byte_sequencer

Load/store sequencer that sits between the CPU datapath and the byte-addressable data port of `Mem`, acting as the initiator of that port. It accepts one RISC-V load/store request at a time, drives `DataAddr`/`DataSize`/`DataIn`/`WE`, and sign- or zero-extends load data from `DataOut`. When enabled, it splits misaligned halfword and word accesses into little-endian byte beats.

## Interface
- AW, 32, address width of request and memory address ports.
- clk  in  1  clock; all state updates on the falling edge, matching `Mem`/`RegFile`/`Reg`.
- RST  in  1  reset, asynchronous, active-low.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer idle; a request is accepted when valid and ready are both high.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V width code: 000 B, 001 H, 010 W, 100 BU (load only), 101 HU (load only).
- req_addr  in  AW  byte address.
- req_wdata  in  32  store data, right-justified.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  valid with resp_valid: illegal funct3, or misaligned access with the feature compiled out.
- mem_addr  out  AW  to `DataAddr`.
- mem_size  out  2  to `DataSize`: 00 byte, 01 half, 10 word.
- mem_wdata  out  32  to `DataIn`.
- mem_we  out  1  to `WE`.
- mem_rdata  in  32  from `DataOut`, combinational. Byte reads arrive replicated ×4; halfword reads arrive replicated ×2.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE:
  - req_ready=1.
  - On accept, latch we, funct3, addr, and wdata, then classify the request.
  - Illegal funct3 (load 011/110/111; store 011/1xx): go to DONE with err=1 and no memory beat.
- Classification:
  - aligned = byte, halfword with addr[0]=0, or word with addr[1:0]=00.
  - An aligned access takes one beat with native mem_size.
  - A misaligned access takes N byte beats: N=2 for H/HU, N=4 for W.
- ACCESS, beat k (k=0..N-1):
  - mem_addr = addr+k, modulo 2^AW.
  - mem_size = 00 for split beats, native size for aligned beats.
  - Store: mem_we=1. mem_wdata = wdata for aligned beats, {4{wdata byte k}} for split beats.
  - Load: mem_we=0. Byte k is captured from mem_rdata[7:0] into assembly register bits [8k+7:8k] at the falling edge that ends the beat. An aligned beat captures the full width.
  - After the last beat, go to DONE.
- DONE:
  - resp_valid=1 for one cycle, then return to IDLE.
  - Load extension: B sign-extends bit 7, BU zero-extends bit 7, H sign-extends bit 15, HU zero-extends bit 15, W passes through.
  - Store: resp_rdata=0.
- Outside ACCESS, all mem_* outputs are 0. mem_* outputs are decoded from registered state only and never from req_* inputs.
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_addr=0, mem_size=00, mem_wdata=0, mem_we=0, assembly register 0.

## Timing
- Accept edge is the falling edge with req_valid&req_ready. The first beat is presented the following cycle.
- Latency from accept edge to resp_valid high:
  - aligned: 2 cycles (1 beat + DONE).
  - split halfword: 3 cycles.
  - split word: 5 cycles.
  - error: 1 cycle.
- A store beat commits in `Mem` at the falling edge that ends the beat, the same edge on which the FSM advances.
- req_ready=0 in ACCESS and DONE. A new request cannot be accepted in the DONE cycle; the earliest next accept is the first IDLE cycle. Requests held across busy cycles are not dropped: the caller holds req_valid.
- Reset asserted mid-operation:
  - Immediately return to IDLE and drop mem_we, with no resp_valid.
  - Store beats already committed remain in memory; partial stores are not rolled back.
- Address wrap: a split access at 0xFFFFFFFE wraps its later bytes to 0x00000000 upward with no error.

## Configuration
- LSU_MISALIGN_EN defined:
  - Misaligned H/HU/W requests are split into byte beats as above.
- LSU_MISALIGN_EN undefined:
  - Misaligned H/HU/W requests go IDLE→DONE with resp_err=1 and resp_rdata=0, with no memory beat and no write.
  - Aligned behaviour is unchanged.
  - The beat counter and assembly shifter are not compiled in.

## Test plan
- Aligned LW at 0x100, with Mem[0x100..0x103]=78 56 34 12: resp_rdata=0x12345678 two cycles after accept, one beat with mem_size=10.
- LB at 0x101=0x80 gives 0xFFFFFF80. LBU at the same address gives 0x00000080. LHU at 0x102, with bytes 0xFE 0xFF, gives 0x0000FFFE.
- SW 0xAABBCCDD at 0x203 (feature on): bytes 0x203..0x206 become DD CC BB AA over 4 byte beats, with resp_valid 5 cycles after accept. Repeated with the feature off: resp_err=1, memory unchanged, resp_valid 1 cycle after accept.
- Load with funct3=011 or store with funct3=100: resp_err=1, resp_rdata=0, no cycle with mem_we=1.
- RST pulsed low during beat 2 of the SW at 0x203: only bytes 0x203 and 0x204 are written. Outputs return to reset values immediately, with no resp_valid.
- Back-to-back requests with req_valid held high: second accept occurs exactly in the first IDLE cycle after DONE, and req_ready stays 0 throughout ACCESS and DONE.
